// File: rtl/trap_sequencer.sv
// Trap/return sequencer: arbitrates writeback exceptions, mret and machine
// interrupts, then issues one system-jump pulse with matching CSR strobes.
module trap_sequencer #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        wbk_valid_i,
    input  logic [31:0] wbk_pc_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic [2:0]  irq_i,
    input  logic [2:0]  irq_en_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        sys_jump_o,
    output logic [31:0] sys_jump_addr_o,
    output logic        csr_trap_we_o,
    output logic        csr_mret_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_JUMP = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_sys_jump;
    logic        r_trap_we;
    logic        r_mret;
    logic [31:0] r_jump_addr;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic        w_sys_jump_nxt;
    logic        w_trap_we_nxt;
    logic        w_mret_nxt;
    logic [31:0] w_jump_addr_nxt;
    logic [31:0] w_mepc_nxt;
    logic [31:0] w_mcause_nxt;
    logic [31:0] w_mtval_nxt;

    logic [2:0]  w_irq_act;
    logic        w_irq_ok;
    logic [3:0]  w_irq_cause;
    logic [31:0] w_base;
    logic [31:0] w_irq_target;
    logic [31:0] w_mret_target;

    assign w_irq_act     = irq_i & irq_en_i;
    assign w_irq_ok      = (w_irq_act != 3'b000) && mstatus_mie_i && wbk_valid_i;
    assign w_base        = mtvec_i & 32'hFFFF_FFFC;
    assign w_mret_target = mepc_i & 32'hFFFF_FFFC;
    // Vectored mode offsets the base by 4*cause; the add wraps at 32 bits.
    assign w_irq_target  = (mtvec_i[1:0] == 2'b01)
                           ? (w_base + {26'b0, w_irq_cause, 2'b00}) : w_base;

    // Interrupt sub-priority: external, then software, then timer.
    always_comb begin
        if (w_irq_act[2]) begin
            w_irq_cause = 4'd11;
        end else if (w_irq_act[1]) begin
            w_irq_cause = 4'd3;
        end else begin
            w_irq_cause = 4'd7;
        end
    end

    // Next-state, hold counter and next output register values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sys_jump_nxt  = 1'b0;
        w_trap_we_nxt   = 1'b0;
        w_mret_nxt      = 1'b0;
        w_jump_addr_nxt = r_jump_addr;
        w_mepc_nxt      = r_mepc;
        w_mcause_nxt    = r_mcause;
        w_mtval_nxt     = r_mtval;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (r_state == ST_HOLD) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end
                end else begin
                    w_cnt_nxt = 4'd0;
                end
                // An accepted event overrides the hold countdown above.
                if (!stall_i && exc_valid_i) begin
                    w_state_nxt     = ST_JUMP;
                    w_cnt_nxt       = 4'd0;
                    w_sys_jump_nxt  = 1'b1;
                    w_trap_we_nxt   = 1'b1;
                    w_jump_addr_nxt = w_base;
                    w_mepc_nxt      = wbk_pc_i;
                    w_mcause_nxt    = {28'b0, exc_cause_i};
                    w_mtval_nxt     = exc_tval_i;
                end else if (!stall_i && mret_i) begin
                    w_state_nxt     = ST_JUMP;
                    w_cnt_nxt       = 4'd0;
                    w_sys_jump_nxt  = 1'b1;
                    w_mret_nxt      = 1'b1;
                    w_jump_addr_nxt = w_mret_target;
                end else if (!stall_i && w_irq_ok && (r_state == ST_IDLE)) begin
                    w_state_nxt     = ST_JUMP;
                    w_cnt_nxt       = 4'd0;
                    w_sys_jump_nxt  = 1'b1;
                    w_trap_we_nxt   = 1'b1;
                    w_jump_addr_nxt = w_irq_target;
                    w_mepc_nxt      = wbk_pc_i;
                    w_mcause_nxt    = {1'b1, 27'b0, w_irq_cause};
                    w_mtval_nxt     = 32'd0;
                end else begin
                    w_sys_jump_nxt  = 1'b0;
                end
            end
            ST_JUMP: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = HOLD_LOAD;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sys_jump  <= 1'b0;
            r_trap_we   <= 1'b0;
            r_mret      <= 1'b0;
            r_jump_addr <= 32'd0;
            r_mepc      <= 32'd0;
            r_mcause    <= 32'd0;
            r_mtval     <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sys_jump  <= w_sys_jump_nxt;
            r_trap_we   <= w_trap_we_nxt;
            r_mret      <= w_mret_nxt;
            r_jump_addr <= w_jump_addr_nxt;
            r_mepc      <= w_mepc_nxt;
            r_mcause    <= w_mcause_nxt;
            r_mtval     <= w_mtval_nxt;
        end
    end

    assign sys_jump_o      = r_sys_jump;
    assign sys_jump_addr_o = r_jump_addr;
    assign csr_trap_we_o   = r_trap_we;
    assign csr_mret_o      = r_mret;
    assign mepc_o          = r_mepc;
    assign mcause_o        = r_mcause;
    assign mtval_o         = r_mtval;
    assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a vector table for single events plus
// hand-written sequences for hold-off, stall, preemption, reset and masking.
module tb_trap_sequencer;

    localparam int unsigned HOLDOFF = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        wbk_valid_i;
    logic [31:0] wbk_pc_i;
    logic        exc_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_tval_i;
    logic        mret_i;
    logic [2:0]  irq_i;
    logic [2:0]  irq_en_i;
    logic        mstatus_mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        sys_jump_o;
    logic [31:0] sys_jump_addr_o;
    logic        csr_trap_we_o;
    logic        csr_mret_o;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [31:0] mtval_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.HOLDOFF(HOLDOFF)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
        .wbk_valid_i(wbk_valid_i), .wbk_pc_i(wbk_pc_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
        .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .sys_jump_o(sys_jump_o), .sys_jump_addr_o(sys_jump_addr_o),
        .csr_trap_we_o(csr_trap_we_o), .csr_mret_o(csr_mret_o),
        .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o), .busy_o(busy_o)
    );

    typedef struct {
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        mret;
        logic [2:0]  irq;
        logic [2:0]  en;
        logic        mie;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        e_jump;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_mret;
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic [31:0] e_mtval;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_events();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        irq_i       = 3'b000;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 32) begin
            tick();
            n++;
        end
        chk({nm, "_idle_timeout"}, busy_o, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          exc cause tval          mret irq     en      mie   valid pc            mtvec         mepc          jmp addr          we    mret  mepc          mcause        mtval
        vecs[0]  = '{1'b1, 4'd2,  32'hFFFF_FFFF, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0000_1040, 32'h0000_0101, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_1040, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0101, 32'h0, 1'b1, 32'h0000_011C, 1'b1, 1'b0, 32'h0000_0200, 32'h8000_0007, 32'h0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b010, 3'b010, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_2000, 32'h0, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_0300, 32'h8000_0003, 32'h0};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_1001, 32'h0, 1'b1, 32'h0000_102C, 1'b1, 1'b0, 32'h0000_0400, 32'h8000_000B, 32'h0};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b011, 3'b010, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0101, 32'h0, 1'b1, 32'h0000_010C, 1'b1, 1'b0, 32'h0000_0500, 32'h8000_0003, 32'h0};
        vecs[5]  = '{1'b1, 4'd11, 32'h0,         1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0000_0600, 32'h0000_0101, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_000B, 32'h0};
        vecs[6]  = '{1'b1, 4'd3,  32'h0000_0700, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0400, 32'h0000_1234, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0003, 32'h0000_0700};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,         1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 32'h0000_0999, 32'h0000_0400, 32'h0000_0803, 1'b1, 32'h0000_0800, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0003, 32'h0000_0700};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 32'h0000_0800, 32'hFFFF_FFF1, 32'h0, 1'b1, 32'h0000_001C, 1'b1, 1'b0, 32'h0000_0800, 32'h8000_000B, 32'h0};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b100, 3'b100, 1'b0, 1'b1, 32'h0000_0900, 32'h0000_0101, 32'h0, 1'b0, 32'h0000_001C, 1'b0, 1'b0, 32'h0000_0800, 32'h8000_000B, 32'h0};
        vecs[10] = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0101, 32'h0, 1'b0, 32'h0000_001C, 1'b0, 1'b0, 32'h0000_0800, 32'h8000_000B, 32'h0};
        vecs[11] = '{1'b0, 4'd0,  32'h0,         1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0000_0900, 32'h0000_0101, 32'h0, 1'b0, 32'h0000_001C, 1'b0, 1'b0, 32'h0000_0800, 32'h8000_000B, 32'h0};

        rst_i = 1'b0; stall_i = 1'b0; wbk_valid_i = 1'b0; wbk_pc_i = 32'h0;
        exc_valid_i = 1'b0; exc_cause_i = 4'd0; exc_tval_i = 32'h0; mret_i = 1'b0;
        irq_i = 3'b000; irq_en_i = 3'b000; mstatus_mie_i = 1'b0;
        mtvec_i = 32'h0; mepc_i = 32'h0;
        tick(); tick();
        chk("rst_jump", sys_jump_o, 1'b0);
        chk("rst_addr", sys_jump_addr_o, 32'h0);
        chk("rst_we", csr_trap_we_o, 1'b0);
        chk("rst_mret", csr_mret_o, 1'b0);
        chk("rst_mepc", mepc_o, 32'h0);
        chk("rst_mcause", mcause_o, 32'h0);
        chk("rst_mtval", mtval_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        rst_i = 1'b1;

        // Table: one event per vector, checked in the pulse cycle, then the hold window.
        for (int i = 0; i < 12; i++) begin
            tick();
            exc_valid_i = vecs[i].exc;   exc_cause_i = vecs[i].cause; exc_tval_i = vecs[i].tval;
            mret_i = vecs[i].mret;       irq_i = vecs[i].irq;         irq_en_i = vecs[i].en;
            mstatus_mie_i = vecs[i].mie; wbk_valid_i = vecs[i].valid; wbk_pc_i = vecs[i].pc;
            mtvec_i = vecs[i].mtvec;     mepc_i = vecs[i].mepc;
            tick();
            chk($sformatf("v%0d_jump", i), sys_jump_o, vecs[i].e_jump);
            chk($sformatf("v%0d_addr", i), sys_jump_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_we", i), csr_trap_we_o, vecs[i].e_we);
            chk($sformatf("v%0d_mret", i), csr_mret_o, vecs[i].e_mret);
            chk($sformatf("v%0d_mepc", i), mepc_o, vecs[i].e_mepc);
            chk($sformatf("v%0d_mcause", i), mcause_o, vecs[i].e_mcause);
            chk($sformatf("v%0d_mtval", i), mtval_o, vecs[i].e_mtval);
            chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_jump);
            clear_events();
            if (vecs[i].e_jump) begin
                for (int k = 0; k < int'(HOLDOFF); k++) begin
                    tick();
                    chk($sformatf("v%0d_hold%0d_jump", i, k), sys_jump_o, 1'b0);
                    chk($sformatf("v%0d_hold%0d_we", i, k), csr_trap_we_o, 1'b0);
                    chk($sformatf("v%0d_hold%0d_busy", i, k), busy_o, 1'b1);
                end
                tick();
                chk($sformatf("v%0d_done_busy", i), busy_o, 1'b0);
            end
        end

        // mret beats simultaneous interrupts; the interrupt follows the hold window.
        tick();
        irq_i = 3'b111; irq_en_i = 3'b111; mstatus_mie_i = 1'b1; wbk_valid_i = 1'b1;
        mret_i = 1'b1; mepc_i = 32'h0000_0803; mtvec_i = 32'h0000_0101; wbk_pc_i = 32'h0000_0900;
        tick();
        chk("prio_mret", csr_mret_o, 1'b1);
        chk("prio_we", csr_trap_we_o, 1'b0);
        chk("prio_addr", sys_jump_addr_o, 32'h0000_0800);
        mret_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("prio_wait%0d", k), sys_jump_o, 1'b0);
        end
        tick();
        chk("prio_irq_jump", sys_jump_o, 1'b1);
        chk("prio_irq_mcause", mcause_o, 32'h8000_000B);
        chk("prio_irq_addr", sys_jump_addr_o, 32'h0000_012C);
        chk("prio_irq_mepc", mepc_o, 32'h0000_0900);
        irq_i = 3'b000;
        wait_idle("prio");

        // Timer interrupt raised just after a jump waits out the hold window.
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; wbk_pc_i = 32'h0000_1100;
        exc_tval_i = 32'h0; mtvec_i = 32'h0000_0101;
        tick();
        chk("hold_exc_jump", sys_jump_o, 1'b1);
        exc_valid_i = 1'b0; irq_i = 3'b001; irq_en_i = 3'b001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_wait%0d", k), sys_jump_o, 1'b0);
        end
        tick();
        chk("hold_irq_jump", sys_jump_o, 1'b1);
        chk("hold_irq_mcause", mcause_o, 32'h8000_0007);
        chk("hold_irq_addr", sys_jump_addr_o, 32'h0000_011C);
        irq_i = 3'b000;
        wait_idle("hold");

        // Stall blocks acceptance; stall during JUMP neither delays nor repeats the pulse.
        stall_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 4'd11;
        wbk_pc_i = 32'h0000_1200; exc_tval_i = 32'h0000_0005;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stall_wait%0d", k), sys_jump_o, 1'b0);
        end
        stall_i = 1'b0;
        tick();
        chk("stall_jump", sys_jump_o, 1'b1);
        chk("stall_mepc", mepc_o, 32'h0000_1200);
        chk("stall_mcause", mcause_o, 32'h0000_000B);
        stall_i = 1'b1; exc_valid_i = 1'b0;
        tick();
        chk("stall_nodup", sys_jump_o, 1'b0);
        chk("stall_busy", busy_o, 1'b1);
        stall_i = 1'b0;
        wait_idle("stall");

        // An exception during HOLD preempts it and restarts the hold window.
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; wbk_pc_i = 32'h0000_1400;
        exc_tval_i = 32'h0; mtvec_i = 32'h0000_0200;
        tick();
        chk("pre_first_jump", sys_jump_o, 1'b1);
        exc_valid_i = 1'b0;
        tick();
        chk("pre_hold_jump", sys_jump_o, 1'b0);
        chk("pre_hold_busy", busy_o, 1'b1);
        exc_valid_i = 1'b1; exc_cause_i = 4'd11; wbk_pc_i = 32'h0000_1404; exc_tval_i = 32'h0000_0077;
        tick();
        chk("pre_second_jump", sys_jump_o, 1'b1);
        chk("pre_second_mepc", mepc_o, 32'h0000_1404);
        chk("pre_second_mtval", mtval_o, 32'h0000_0077);
        chk("pre_second_addr", sys_jump_addr_o, 32'h0000_0200);
        exc_valid_i = 1'b0;
        for (int k = 0; k < int'(HOLDOFF); k++) begin
            tick();
            chk($sformatf("pre_rehold%0d_busy", k), busy_o, 1'b1);
        end
        tick();
        chk("pre_done_busy", busy_o, 1'b0);

        // Reset in the JUMP cycle clears everything and emits nothing later.
        tick();
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; wbk_pc_i = 32'h0000_1300;
        exc_tval_i = 32'h0000_0001; mtvec_i = 32'h0000_0101;
        tick();
        chk("mrst_jump", sys_jump_o, 1'b1);
        rst_i = 1'b0; exc_valid_i = 1'b0;
        tick();
        chk("mrst_jump0", sys_jump_o, 1'b0);
        chk("mrst_addr0", sys_jump_addr_o, 32'h0);
        chk("mrst_we0", csr_trap_we_o, 1'b0);
        chk("mrst_mret0", csr_mret_o, 1'b0);
        chk("mrst_mepc0", mepc_o, 32'h0);
        chk("mrst_mcause0", mcause_o, 32'h0);
        chk("mrst_mtval0", mtval_o, 32'h0);
        chk("mrst_busy0", busy_o, 1'b0);
        rst_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mrst_after%0d_jump", k), sys_jump_o, 1'b0);
            chk($sformatf("mrst_after%0d_busy", k), busy_o, 1'b0);
        end

        // Masking: global MIE off, then writeback invalid; then both enabled.
        irq_i = 3'b100; irq_en_i = 3'b100; mstatus_mie_i = 1'b0; wbk_valid_i = 1'b1;
        wbk_pc_i = 32'h0000_1500;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("mask_mie%0d", k), sys_jump_o, 1'b0);
        end
        mstatus_mie_i = 1'b1; wbk_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("mask_valid%0d", k), sys_jump_o, 1'b0);
        end
        wbk_valid_i = 1'b1;
        tick();
        chk("mask_release_jump", sys_jump_o, 1'b1);
        chk("mask_release_mcause", mcause_o, 32'h8000_000B);
        chk("mask_release_addr", sys_jump_addr_o, 32'h0000_012C);
        irq_i = 3'b000;
        wait_idle("mask");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Initiator for the pipeline's system-jump path.
- Monitors the writeback stage for synchronous exceptions, `mret` and pending machine interrupts, and arbitrates among them.
- For the winning event it sequences one trap entry or return: a CSR update strobe plus a single-cycle `sys_jump_o` pulse and target address, which drives the pipeline controller's system-jump input.
- Sits between the writeback stage, the CSR file and the PC unit.

Parameters:
- HOLDOFF, 2: cycles after a jump during which new interrupts are masked (lets the flushed pipeline refill); legal range 1..15.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-low
- stall_i  in  1  pipeline stalled; no event is accepted while high
- wbk_valid_i  in  1  writeback holds a valid instruction
- wbk_pc_i  in  32  PC of the writeback instruction
- exc_valid_i  in  1  writeback instruction raised an exception
- exc_cause_i  in  4  exception code (2 illegal, 3 ebreak, 11 ecall, ...)
- exc_tval_i  in  32  faulting value
- mret_i  in  1  writeback instruction is `mret`
- irq_i  in  3  pending {ext, sw, timer}
- irq_en_i  in  3  {MEIE, MSIE, MTIE}
- mstatus_mie_i  in  1  global interrupt enable
- mtvec_i  in  32  trap vector CSR
- mepc_i  in  32  current `mepc` (used by `mret`)
- sys_jump_o  out  1  one-cycle redirect pulse
- sys_jump_addr_o  out  32  redirect target
- csr_trap_we_o  out  1  pulse: write `mepc`/`mcause`/`mtval`, MPIE<=MIE, MIE<=0
- csr_mret_o  out  1  pulse: MIE<=MPIE, MPIE<=1
- mepc_o  out  32  value for `mepc`
- mcause_o  out  32  value for `mcause`
- mtval_o  out  32  value for `mtval`
- busy_o  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, JUMP, HOLD.
- Reset (rst_i==0 at a clock edge):
  - state goes to IDLE and the hold counter clears to 0.
  - All outputs are 0 the following cycle.
  - A reset during JUMP or HOLD aborts the sequence; no pulse is emitted afterwards.
- Event acceptance:
  - Evaluated in IDLE and HOLD, only when stall_i==0.
  - Fixed priority: exception > `mret` > interrupt.
  - Interrupts are additionally blocked in HOLD.
- Interrupt eligibility: `(irq_i & irq_en_i) != 0`, mstatus_mie_i==1 and wbk_valid_i==1.
- Interrupt sub-priority: ext (cause 11) > sw (cause 3) > timer (cause 7).
- Acceptance at edge t registers the following, all held stable in JUMP:
  - Exception: mepc_o=wbk_pc_i, mcause_o={28'b0, exc_cause_i}, mtval_o=exc_tval_i, target=`{mtvec_i[31:2], 2'b00}`.
  - Interrupt: mepc_o=wbk_pc_i, mcause_o={1'b1, 27'b0, cause[3:0]}, mtval_o=0.
    - Target is base+4*cause if mtvec_i[1:0]==2'b01, else base. Arithmetic is 32-bit and wraps.
  - `mret`: target=`{mepc_i[31:2], 2'b00}`; mepc_o, mcause_o and mtval_o are unchanged.
- JUMP (exactly one cycle; latency from accepting edge to pulse = 1 cycle):
  - sys_jump_o=1 with sys_jump_addr_o valid.
  - csr_trap_we_o=1 for a trap, or csr_mret_o=1 for `mret`; never both.
  - The next state is HOLD with counter=HOLDOFF.
- HOLD:
  - Counter decrements each cycle; the state returns to IDLE when it reaches 1.
  - An exception or `mret` in HOLD preempts the hold: go to JUMP and reload the counter afterwards.
- Pulse outputs (sys_jump_o, csr_trap_we_o, csr_mret_o) are 0 in IDLE and HOLD.
- sys_jump_addr_o and mepc_o/mcause_o/mtval_o hold their last values outside JUMP.
- Simultaneous events:
  - exc_valid_i and mret_i together: treat as an exception.
  - An interrupt arriving with an exception: the interrupt stays pending and is taken after HOLD if still eligible.
- stall_i is ignored in JUMP; the pulse is never delayed or repeated.

Test Plan:
- Illegal instruction: exc_valid_i=1, cause=2, wbk_pc_i=0x0000_1040, tval=0xFFFF_FFFF, mtvec=0x0000_0101 → next cycle sys_jump_o=1, addr=0x0000_0100, mepc_o=0x1040, mcause_o=2, mtval_o=0xFFFF_FFFF, csr_trap_we_o=1 for exactly 1 cycle; busy_o high for 1+HOLDOFF cycles.
- Vectored timer interrupt: irq_i=001, irq_en_i=001, mie=1, mtvec=0x0000_0101, wbk_pc_i=0x200 → addr=0x0000_011C, mcause_o=0x8000_0007, mepc_o=0x200.
- Priority: irq_i=111 with all enables set, together with mret_i=1 and mepc_i=0x0000_0803 → csr_mret_o=1, addr=0x0000_0800; after HOLD, the interrupt is taken with mcause_o=0x8000_000B.
- Hold-off and stall: a timer interrupt raised in the cycle after the jump is not taken until HOLDOFF=2 cycles have elapsed. With stall_i=1 and exc_valid_i=1, no pulse occurs until stall_i falls; the pulse then follows 1 cycle later.
- Reset mid-sequence: rst_i=0 in the JUMP cycle → the following cycle shows all outputs 0 and the state is IDLE; no later sys_jump_o appears.
- Masking: mstatus_mie_i=0 or wbk_valid_i=0 with irq_i=100 and irq_en_i=100 → no sys_jump_o for 20 cycles.
